mybusmatrix5x7_input_stage: RTL and testbench
=============================================

// Module: mybusmatrix5x7_input_stage
// PURPOSE
//  Per-master input stage of the 5x7 AHB bus matrix; sits between one master (slave-side AHB-Lite port) and the
//  address decoder / output-stage arbiters (req_portN sources). Holds an address phase that its target output
//  stage cannot take this cycle, stalls the master meanwhile, and returns data-phase HREADYOUT/HRESP.
// PARAMETERS
//  ADDR_W   32  address width of HADDRS / addr_op
//  MST_W     4  width of HMASTERS / master_op
// PORTS
//  HCLK         in   1       AHB clock; single clock domain
//  HRESETn      in   1       reset, synchronous, active-low
//  HSELS        in   1       master-side select
//  HADDRS       in   ADDR_W  address
//  HTRANSS      in   2       transfer type
//  HWRITES      in   1       write
//  HSIZES       in   3       size
//  HBURSTS      in   3       burst
//  HPROTS       in   4       protection
//  HMASTERS     in   MST_W   master id
//  HMASTLOCKS   in   1       locked transfer
//  HREADYS      in   1       bus HREADY seen by master
//  active_trans in   1       an output stage grants this port AND its HREADYM=1 (address phase taken this cycle)
//  readyout_dp  in   1       data-phase HREADYOUT from owning output stage
//  resp_dp      in   1       data-phase HRESP from owning output stage (0=OKAY,1=ERROR)
//  sel_op,addr_op,trans_op,write_op,size_op,burst_op,prot_op,master_op,lock_op  out  (as inputs)  to decoder/arbiters
//  HREADYOUTS   out  1       ready to master
//  HRESPS       out  1       response to master
// BEHAVIOUR
//  - new_trans = HSELS & HTRANSS[1] & HREADYS (NONSEQ/SEQ only; IDLE/BUSY never captured).
//  - pend (reg): set at edge when new_trans & ~active_trans & ~pend; cleared at edge when pend & active_trans.
//    On set, holding reg captures all address/control. Holding reg changes ONLY on pend set.
//  - Output mux: pend=1 -> holding reg; pend=0 -> live master signals (zero-latency pass-through).
//  - While pend: trans_op forced NONSEQ (2'b10) if captured SEQ; burst_op forced INCR (3'b001) if captured burst
//    was not SINGLE/INCR (arbitration may interleave other masters). sel_op=1, other fields unmodified.
//  - dp_active (reg): next = accept ? 1 : (readyout_dp ? 0 : dp_active), accept = active_trans & sel_op & trans_op[1].
//    Back-to-back accept while readyout_dp=1 keeps dp_active=1.
//  - HREADYOUTS = pend ? 0 : dp_active ? readyout_dp : 1.  HRESPS = (~pend & dp_active) ? resp_dp : 0.
//    Unselected/IDLE/BUSY -> zero-wait OKAY. Two-cycle ERROR is formed downstream; passed through unchanged.
//  - pend and dp_active may both be 1 (previous data phase finishing while next address is held); HREADYOUTS
//    stays 0 until pend clears and then follows readyout_dp of the newly accepted transfer.
//  - Latency: unheld transfer adds 0 cycles; a held transfer adds exactly N cycles, N = cycles with active_trans=0.
//  - Reset (sync, HRESETn=0 at HCLK edge, including mid-transfer): pend=0, dp_active=0, holding reg=0;
//    after that edge HREADYOUTS=1, HRESPS=0, outputs follow live inputs. Held transfer is discarded.
// STRUCTURE
//  - mybusmatrix5x7_pkg: HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HBURST codes (SINGLE/INCR/...), HRESP OKAY/ERROR.
//  - Sub-module mybusmatrix5x7_hold_reg: capture-enabled register bank for the address/control bundle.
//  - Top: pend/dp_active FSM, SEQ->NONSEQ/burst rewrite, output mux, HREADYOUTS/HRESPS logic.
// TESTING
//  1 NONSEQ write 0x2000_0010 with active_trans=1 same cycle -> addr_op live, pend stays 0, HREADYOUTS=readyout_dp next.
//  2 NONSEQ read 0x4000_0000, active_trans=0 for 3 cycles -> pend=1, addr_op held 0x4000_0000, HREADYOUTS=0 for
//    3 cycles, then accept; total stall = 3 cycles.
//  3 SEQ beat of INCR4 held -> trans_op=2'b10, burst_op=3'b001 while pend; original HADDRS preserved.
//  4 Data phase with readyout_dp=0,resp_dp=1 then readyout_dp=1,resp_dp=1 -> HREADYOUTS 0,1; HRESPS 1,1.
//  5 HRESETn=0 for one edge while pend=1 -> pend=0, HREADYOUTS=1, HRESPS=0; no spurious accept afterwards.
//  6 IDLE and BUSY with HSELS=1, active_trans=0 -> never captured, HREADYOUTS=1, HRESPS=0.

Source files
------------

// File: rtl/mybusmatrix5x7_pkg.sv
// Shared AHB encodings for the 5x7 bus matrix, plus the address-phase rewrite
// helpers applied to a held transfer.
package mybusmatrix5x7_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'b000,
    HB_INCR   = 3'b001,
    HB_WRAP4  = 3'b010,
    HB_INCR4  = 3'b011,
    HB_WRAP8  = 3'b100,
    HB_INCR8  = 3'b101,
    HB_WRAP16 = 3'b110,
    HB_INCR16 = 3'b111
  } hburst_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // A held beat may be interleaved with other masters, so it must restart as a
  // fresh NONSEQ of an undefined-length burst.
  function automatic logic [1:0] held_trans(input logic [1:0] t);
    return (t == HT_SEQ) ? HT_NONSEQ : t;
  endfunction

  function automatic logic [2:0] held_burst(input logic [2:0] b);
    return (b == HB_SINGLE || b == HB_INCR) ? b : HB_INCR;
  endfunction

endpackage

// File: rtl/mybusmatrix5x7_input_stage_if.sv
// Bus bundle of one input stage: master-side AHB-Lite inputs, decoder/arbiter
// outputs and the data-phase feedback from the owning output stage.
interface mybusmatrix5x7_input_stage_if #(
  parameter int ADDR_W = 32,
  parameter int MST_W  = 4
);
  logic              HSELS;
  logic [ADDR_W-1:0] HADDRS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic [3:0]        HPROTS;
  logic [MST_W-1:0]  HMASTERS;
  logic              HMASTLOCKS;
  logic              HREADYS;
  logic              active_trans;
  logic              readyout_dp;
  logic              resp_dp;

  logic              sel_op;
  logic [ADDR_W-1:0] addr_op;
  logic [1:0]        trans_op;
  logic              write_op;
  logic [2:0]        size_op;
  logic [2:0]        burst_op;
  logic [3:0]        prot_op;
  logic [MST_W-1:0]  master_op;
  logic              lock_op;
  logic              HREADYOUTS;
  logic              HRESPS;

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS,
           HMASTLOCKS, HREADYS, active_trans, readyout_dp, resp_dp,
    output sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op,
           master_op, lock_op, HREADYOUTS, HRESPS
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS,
           HMASTLOCKS, HREADYS, active_trans, readyout_dp, resp_dp,
    input  sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op,
           master_op, lock_op, HREADYOUTS, HRESPS
  );

endinterface

// File: rtl/mybusmatrix5x7_hold_reg.sv
// Capture-enabled register bank holding one address/control bundle; it only
// loads on cap_en_i and clears on synchronous reset.
module mybusmatrix5x7_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         cap_en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] hold_q, hold_d;

  always_comb hold_d = cap_en_i ? d_i : hold_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) hold_q <= '0;
    else         hold_q <= hold_d;
  end

  assign q_o = hold_q;

endmodule

// File: rtl/mybusmatrix5x7_input_stage.sv
// Per-master input stage: holds an address phase its output stage cannot take
// yet, stalls the master meanwhile and returns data-phase HREADYOUT/HRESP.
module mybusmatrix5x7_input_stage
  import mybusmatrix5x7_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MST_W  = 4
) (
  input  logic HCLK,
  input  logic HRESETn,
  mybusmatrix5x7_input_stage_if.slave bus
);

  localparam int HOLD_W = ADDR_W + MST_W + 14;

  logic              pend_q, pend_d;
  logic              dp_active_q, dp_active_d;
  logic              new_trans, cap_en, accept;
  logic [HOLD_W-1:0] live_w, held_w;

  logic [ADDR_W-1:0] h_addr;
  logic [1:0]        h_trans;
  logic              h_write;
  logic [2:0]        h_size;
  logic [2:0]        h_burst;
  logic [3:0]        h_prot;
  logic [MST_W-1:0]  h_master;
  logic              h_lock;

  assign new_trans = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
  assign cap_en    = new_trans & ~bus.active_trans & ~pend_q;

  assign live_w = {bus.HADDRS, bus.HTRANSS, bus.HWRITES, bus.HSIZES, bus.HBURSTS,
                   bus.HPROTS, bus.HMASTERS, bus.HMASTLOCKS};

  mybusmatrix5x7_hold_reg #(.W(HOLD_W)) u_hold (
    .clk_i    (HCLK),
    .rst_ni   (HRESETn),
    .cap_en_i (cap_en),
    .d_i      (live_w),
    .q_o      (held_w)
  );

  assign {h_addr, h_trans, h_write, h_size, h_burst, h_prot, h_master, h_lock} = held_w;

  always_comb begin
    if (pend_q) begin
      bus.sel_op    = 1'b1;
      bus.addr_op   = h_addr;
      bus.trans_op  = held_trans(h_trans);
      bus.write_op  = h_write;
      bus.size_op   = h_size;
      bus.burst_op  = held_burst(h_burst);
      bus.prot_op   = h_prot;
      bus.master_op = h_master;
      bus.lock_op   = h_lock;
    end else begin
      bus.sel_op    = bus.HSELS;
      bus.addr_op   = bus.HADDRS;
      bus.trans_op  = bus.HTRANSS;
      bus.write_op  = bus.HWRITES;
      bus.size_op   = bus.HSIZES;
      bus.burst_op  = bus.HBURSTS;
      bus.prot_op   = bus.HPROTS;
      bus.master_op = bus.HMASTERS;
      bus.lock_op   = bus.HMASTLOCKS;
    end
  end

  assign accept = bus.active_trans & bus.sel_op & bus.trans_op[1];

  always_comb begin
    pend_d = pend_q;
    if (pend_q && bus.active_trans) pend_d = 1'b0;
    else if (cap_en)                pend_d = 1'b1;

    dp_active_d = dp_active_q;
    if (accept)               dp_active_d = 1'b1;
    else if (bus.readyout_dp) dp_active_d = 1'b0;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend_q      <= 1'b0;
      dp_active_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      dp_active_q <= dp_active_d;
    end
  end

  // A held address phase masks any data-phase response still in flight.
  assign bus.HREADYOUTS = pend_q ? 1'b0 : (dp_active_q ? bus.readyout_dp : 1'b1);
  assign bus.HRESPS     = (~pend_q & dp_active_q) ? bus.resp_dp : HRESP_OKAY;

endmodule

// File: tb/tb_mybusmatrix5x7_input_stage.sv
// Directed bench for the input stage: drives on the falling edge, checks 1ns
// later, expected values are hand-computed constants.
module tb_mybusmatrix5x7_input_stage;
  import mybusmatrix5x7_pkg::*;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  mybusmatrix5x7_input_stage_if #(.ADDR_W(32), .MST_W(4)) bus ();

  mybusmatrix5x7_input_stage #(.ADDR_W(32), .MST_W(4)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv_idle();
    bus.HSELS = 1'b0; bus.HADDRS = '0; bus.HTRANSS = HT_IDLE; bus.HWRITES = 1'b0;
    bus.HSIZES = '0; bus.HBURSTS = HB_SINGLE; bus.HPROTS = '0; bus.HMASTERS = '0;
    bus.HMASTLOCKS = 1'b0; bus.HREADYS = 1'b1;
    bus.active_trans = 1'b0; bus.readyout_dp = 1'b1; bus.resp_dp = 1'b0;
  endtask

  task automatic drv_nt(input logic [31:0] a, input logic [1:0] t, input logic w, input logic act);
    bus.HSELS = 1'b1; bus.HADDRS = a; bus.HTRANSS = t; bus.HWRITES = w;
    bus.HREADYS = 1'b1; bus.active_trans = act;
  endtask

  task automatic nxt();
    @(negedge HCLK);
  endtask

  initial begin
    // reset state, with data-phase inputs set to values that would show through
    drv_idle();
    bus.readyout_dp = 1'b0; bus.resp_dp = 1'b1;
    repeat (2) nxt();
    #1;
    chk("rst_hready", bus.HREADYOUTS, 1);
    chk("rst_hresp",  bus.HRESPS, 0);
    nxt(); HRESETn = 1'b1; drv_idle();

    // 1: NONSEQ write accepted in the same cycle
    nxt(); drv_nt(32'h2000_0010, HT_NONSEQ, 1'b1, 1'b1); #1;
    chk("t1_addr_live", bus.addr_op, 32'h2000_0010);
    chk("t1_trans_live", bus.trans_op, HT_NONSEQ);
    chk("t1_hready_addr", bus.HREADYOUTS, 1);
    nxt(); drv_idle(); bus.readyout_dp = 1'b0; #1;
    chk("t1_dp_wait", bus.HREADYOUTS, 0);
    bus.readyout_dp = 1'b1; #1;
    chk("t1_dp_done", bus.HREADYOUTS, 1);

    // 2: NONSEQ read held for 3 cycles of active_trans=0
    nxt(); drv_nt(32'h4000_0000, HT_NONSEQ, 1'b0, 1'b0); #1;
    chk("t2_addr_live", bus.addr_op, 32'h4000_0000);
    chk("t2_hready_addr", bus.HREADYOUTS, 1);
    stall = 0;
    for (int c = 1; c <= 4; c++) begin
      nxt();
      bus.HSELS = (c < 4); bus.HADDRS = 32'hDEAD_BEEF; bus.HWRITES = 1'b1;
      bus.HREADYS = (c == 4); bus.active_trans = (c == 3); bus.readyout_dp = 1'b1;
      #1;
      if (c == 1) chk("t2_write_held", bus.write_op, 0);
      if (c <= 3) chk("t2_addr_held", bus.addr_op, 32'h4000_0000);
      if (!bus.HREADYOUTS) stall++;
    end
    chk("t2_stall", stall, 3);

    // 3: SEQ beat of INCR4 held -> rewritten to NONSEQ/INCR
    nxt(); drv_idle(); drv_nt(32'h4000_0004, HT_SEQ, 1'b0, 1'b0);
    bus.HBURSTS = HB_INCR4; bus.HSIZES = 3'd2; bus.HPROTS = 4'hA; bus.HMASTERS = 4'h5;
    #1;
    chk("t3_trans_live", bus.trans_op, HT_SEQ);
    chk("t3_burst_live", bus.burst_op, HB_INCR4);
    nxt(); bus.HTRANSS = HT_IDLE; bus.HADDRS = 32'h0BAD_0BAD; bus.HBURSTS = HB_SINGLE;
    bus.HMASTERS = 4'h0; bus.HREADYS = 1'b0; bus.active_trans = 1'b1; #1;
    chk("t3_trans_held", bus.trans_op, HT_NONSEQ);
    chk("t3_burst_held", bus.burst_op, HB_INCR);
    chk("t3_addr_held",  bus.addr_op, 32'h4000_0004);
    chk("t3_sel_held",   bus.sel_op, 1);
    chk("t3_size_held",  bus.size_op, 2);
    chk("t3_prot_held",  bus.prot_op, 4'hA);
    chk("t3_mst_held",   bus.master_op, 4'h5);
    chk("t3_hready",     bus.HREADYOUTS, 0);
    nxt(); drv_idle(); #1;

    // 4: wait state with ERROR then completion with ERROR
    nxt(); drv_nt(32'h3000_0000, HT_NONSEQ, 1'b1, 1'b1); #1;
    nxt(); drv_idle(); bus.readyout_dp = 1'b0; bus.resp_dp = 1'b1; #1;
    chk("t4_hready0", bus.HREADYOUTS, 0);
    chk("t4_hresp0",  bus.HRESPS, 1);
    nxt(); bus.readyout_dp = 1'b1; bus.resp_dp = 1'b1; #1;
    chk("t4_hready1", bus.HREADYOUTS, 1);
    chk("t4_hresp1",  bus.HRESPS, 1);
    nxt(); #1;
    chk("t4_hresp_idle", bus.HRESPS, 0);

    // 4b: pend overlapping a finishing data phase
    nxt(); drv_idle(); drv_nt(32'h6000_0000, HT_NONSEQ, 1'b1, 1'b1); #1;
    nxt(); drv_nt(32'h6000_0004, HT_NONSEQ, 1'b1, 1'b0); bus.readyout_dp = 1'b0; #1;
    chk("t4b_dp_wait", bus.HREADYOUTS, 0);
    nxt(); bus.HREADYS = 1'b0; bus.HADDRS = 32'hFFFF_FFFF; bus.readyout_dp = 1'b1; bus.resp_dp = 1'b1; #1;
    chk("t4b_pend_hready", bus.HREADYOUTS, 0);
    chk("t4b_pend_hresp",  bus.HRESPS, 0);
    chk("t4b_pend_addr",   bus.addr_op, 32'h6000_0004);
    nxt(); bus.active_trans = 1'b1; #1;
    chk("t4b_accept_cyc", bus.HREADYOUTS, 0);
    nxt(); drv_idle(); bus.readyout_dp = 1'b0; #1;
    chk("t4b_new_dp_wait", bus.HREADYOUTS, 0);
    bus.readyout_dp = 1'b1; #1;
    chk("t4b_new_dp_done", bus.HREADYOUTS, 1);

    // 5: reset while pending discards the held transfer
    nxt(); drv_nt(32'h5000_0000, HT_NONSEQ, 1'b1, 1'b0); #1;
    nxt(); HRESETn = 1'b0; bus.HREADYS = 1'b0; #1;
    chk("t5_pend_before_rst", bus.HREADYOUTS, 0);
    nxt(); HRESETn = 1'b1; drv_idle(); bus.HADDRS = 32'h1234_5678; bus.active_trans = 1'b1;
    bus.resp_dp = 1'b1; #1;
    chk("t5_hready", bus.HREADYOUTS, 1);
    chk("t5_hresp",  bus.HRESPS, 0);
    chk("t5_addr_live", bus.addr_op, 32'h1234_5678);
    chk("t5_sel_live", bus.sel_op, 0);
    nxt(); bus.active_trans = 1'b0; bus.readyout_dp = 1'b0; #1;
    chk("t5_no_accept", bus.HREADYOUTS, 1);

    // 6: IDLE and BUSY are never captured
    nxt(); drv_idle(); drv_nt(32'h7000_0000, HT_IDLE, 1'b0, 1'b0); #1;
    chk("t6_idle_hready", bus.HREADYOUTS, 1);
    nxt(); drv_nt(32'h7000_0040, HT_BUSY, 1'b0, 1'b0); bus.readyout_dp = 1'b0; bus.resp_dp = 1'b1; #1;
    chk("t6_busy_hready", bus.HREADYOUTS, 1);
    chk("t6_busy_hresp",  bus.HRESPS, 0);
    chk("t6_busy_addr",   bus.addr_op, 32'h7000_0040);
    chk("t6_busy_trans",  bus.trans_op, HT_BUSY);
    nxt(); drv_idle(); bus.HADDRS = 32'h0000_0011; bus.readyout_dp = 1'b0; #1;
    chk("t6_after_addr",  bus.addr_op, 32'h0000_0011);
    chk("t6_after_hready", bus.HREADYOUTS, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
